// File: rtl/mdu_pkg.sv
// Shared op codes, FSM states and sizing helpers for the multiply/divide sequencer.
// Divide support is compiled in only when MULDIV_DIV_EN is defined.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  typedef enum logic [2:0] {
    MDU_NOP   = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } mdu_state_e;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned MDU_CNT_W = cnt_width(MDU_WIDTH);

  // Ops that launch the iterative datapath in this build.
  function automatic logic op_starts(input logic [2:0] op);
`ifdef MULDIV_DIV_EN
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
`else
    return (op == MDU_MULT) || (op == MDU_MULTU);
`endif
  endfunction

  // Ops that must be held off while an operation is in flight.
  function automatic logic op_active(input logic [2:0] op);
    return op_starts(op) || (op == MDU_MTHI) || (op == MDU_MTLO);
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational radix-2 iteration: shift-add multiply, or restoring divide step.
// The divide path exists only when MULDIV_DIV_EN is defined.
module mdu_iter_step
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
`ifdef MULDIV_DIV_EN
  input  logic                 div_mode,
`endif
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     m,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0] mul_sum;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;
`endif

  always_comb begin
    // acc = {partial product, remaining multiplier bits}
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    acc_next = {mul_sum, acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    // acc = {partial remainder, dividend bits / quotient bits}
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = shifted - {1'b0, m};
    fits    = (shifted >= {1'b0, m});
    if (div_mode) begin
      if (fits) acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else      acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
`endif
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO and pipeline stall.
// DIV/DIVU are built only when MULDIV_DIV_EN is defined; otherwise they act as NOP.
module muldiv_sequencer
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_req,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  mdu_state_e           state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]     mb;
  logic                 neg_a;
  logic                 neg_b;
  logic                 signed_op;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [2*WIDTH-1:0]   prod_fix;
`ifdef MULDIV_DIV_EN
  logic                 is_div;
  logic [WIDTH-1:0]     q_fix;
  logic [WIDTH-1:0]     r_fix;
`endif

  assign busy  = (state != S_IDLE);
  assign stall = busy & (op_active(op) | rd_req);

  // Operand magnitudes; 0x80..0 stays as the unsigned value 2^(WIDTH-1).
  always_comb begin
`ifdef MULDIV_DIV_EN
    signed_op = (op == MDU_MULT) || (op == MDU_DIV);
`else
    signed_op = (op == MDU_MULT);
`endif
    a_mag = (signed_op && a[WIDTH-1]) ? WIDTH'(-a) : a;
    b_mag = (signed_op && b[WIDTH-1]) ? WIDTH'(-b) : b;
  end

  // Sign correction applied in FIX.
  always_comb begin
    prod_fix = (neg_a ^ neg_b) ? (2*WIDTH)'(-acc) : acc;
`ifdef MULDIV_DIV_EN
    q_fix = (neg_a ^ neg_b) ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    r_fix = neg_a ? WIDTH'(-acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
`endif
  end

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULDIV_DIV_EN
    .div_mode (is_div),
`endif
    .acc      (acc),
    .m        (mb),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      acc   <= '0;
      mb    <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      hi    <= '0;
      lo    <= '0;
`ifdef MULDIV_DIV_EN
      is_div <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (!cancel) begin
            if (op_starts(op)) begin
              acc   <= {{WIDTH{1'b0}}, a_mag};
              mb    <= b_mag;
              neg_a <= signed_op & a[WIDTH-1];
              neg_b <= signed_op & b[WIDTH-1];
              cnt   <= '0;
              state <= S_RUN;
`ifdef MULDIV_DIV_EN
              is_div <= (op == MDU_DIV) || (op == MDU_DIVU);
`endif
            end else if (op == MDU_MTHI) begin
              hi <= a;
            end else if (op == MDU_MTLO) begin
              lo <= a;
            end
          end
        end
        S_RUN: begin
          if (cancel) begin
            state <= S_IDLE;
          end else begin
            acc <= acc_next;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
          end
        end
        S_FIX: begin
          if (!cancel) begin
`ifdef MULDIV_DIV_EN
            if (is_div) begin
              hi <= r_fix;
              lo <= q_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
`else
            {hi, lo} <= prod_fix;
`endif
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table, corner sequences, random vs. model.
// Expectations for DIV/DIVU follow whether MULDIV_DIV_EN is defined.
module tb_muldiv_sequencer;

  localparam logic [2:0] NOP = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3,
                         DIVU = 3'd4, MTHI = 3'd5, MTLO = 3'd6, RSVD = 3'd7;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int LAT = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        rd_req, cancel;
  logic [31:0] hi, lo;
  logic        busy, stall;

  int tests = 0;
  int fails = 0;
  logic [31:0] mhi, mlo;

  muldiv_sequencer dut (
    .clk(clk), .rst(rst), .op(op), .a(a), .b(b), .rd_req(rd_req), .cancel(cancel),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b, eh, el;
    int          cyc;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Architectural result of one op, from plain integer arithmetic.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int cyc);
    logic [63:0] p;
    longint      sq, sr;
    cyc = 0;
    case (o)
      MULT: begin
        p = 64'(longint'($signed(x)) * longint'($signed(y)));
        {mhi, mlo} = p; cyc = LAT;
      end
      MULTU: begin
        p = {32'b0, x} * {32'b0, y};
        {mhi, mlo} = p; cyc = LAT;
      end
      DIV: if (DIV_EN) begin
        cyc = LAT;
        if (y == 32'd0) begin
          mhi = x;
          mlo = x[31] ? 32'h1 : 32'hFFFF_FFFF;
        end else begin
          sq = longint'($signed(x)) / longint'($signed(y));
          sr = longint'($signed(x)) % longint'($signed(y));
          mlo = 32'(sq); mhi = 32'(sr);
        end
      end
      DIVU: if (DIV_EN) begin
        cyc = LAT;
        if (y == 32'd0) begin mhi = x; mlo = 32'hFFFF_FFFF; end
        else begin mlo = x / y; mhi = x % y; end
      end
      MTHI: mhi = x;
      MTLO: mlo = x;
      default: ;
    endcase
  endtask

  // Issue one op, count busy cycles (bounded), then compare hi/lo.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                        input int ecyc);
    int n;
    @(negedge clk); op = o; a = x; b = y;
    @(negedge clk); op = NOP;
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    check({name, " cycles"}, 32'(n), 32'(ecyc));
    check({name, " hi"}, hi, eh);
    check({name, " lo"}, lo, el);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n, c;
    logic [2:0]  ro;
    logic [31:0] rx, ry;

    vecs[0] = '{"mthi",     MTHI,  32'h1234, 32'h0, 32'h1234, 32'h0, 0};
    vecs[1] = '{"mtlo",     MTLO,  32'h5678, 32'h0, 32'h1234, 32'h5678, 0};
    vecs[2] = '{"reserved", RSVD,  32'hFFFF, 32'h9, 32'h1234, 32'h5678, 0};
    vecs[3] = '{"multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, LAT};
    vecs[4] = '{"mult_minmin", MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, LAT};
    vecs[5] = '{"mult_m3x7", MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, LAT};
    vecs[6] = '{"div_m7d2", DIV, 32'hFFFF_FFF9, 32'd2,
                32'hFFFF_FFFF, DIV_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFEB, DIV_EN ? LAT : 0};
    vecs[7] = '{"divu_by0", DIVU, 32'd100, 32'd0,
                DIV_EN ? 32'd100 : 32'hFFFF_FFFF, DIV_EN ? 32'hFFFF_FFFF : 32'hFFFF_FFEB,
                DIV_EN ? LAT : 0};
    vecs[8] = '{"div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                DIV_EN ? 32'h0 : 32'hFFFF_FFFF, DIV_EN ? 32'h8000_0000 : 32'hFFFF_FFEB,
                DIV_EN ? LAT : 0};

    rst = 1'b1; op = NOP; a = '0; b = '0; rd_req = 1'b0; cancel = 1'b0;
    #1;
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset stall", 32'(stall), 32'h0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, vecs[i].cyc);

    // rd_req held through a multiply: stall for the whole busy window.
    @(negedge clk); op = MULT; a = 32'hFFFF_FFFD; b = 32'd7;
    @(negedge clk); op = NOP; rd_req = 1'b1; #1;
    n = 0;
    while (stall && n < 100) begin n++; @(negedge clk); #1; end
    rd_req = 1'b0;
    check("rdreq stall cycles", 32'(n), 32'(LAT));
    check("rdreq hi", hi, 32'hFFFF_FFFF);
    check("rdreq lo", lo, 32'hFFFF_FFEB);

    // Cancel at cnt==10 leaves the previous HI/LO.
    run_op("pre mthi", MTHI, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFEB, 0);
    run_op("pre mtlo", MTLO, 32'h5678, 32'h0, 32'h1234, 32'h5678, 0);
    @(negedge clk); op = MULT; a = 32'd5; b = 32'd5;
    @(negedge clk); op = NOP;
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
    check("cancel busy", 32'(busy), 32'h0);
    check("cancel hi", hi, 32'h1234);
    check("cancel lo", lo, 32'h5678);

    // Cancel in IDLE drops an MTHI and a MULT.
    @(negedge clk); op = MTHI; a = 32'hDEAD; cancel = 1'b1;
    @(negedge clk); op = MULT; a = 32'd3; b = 32'd3;
    @(negedge clk); op = NOP; cancel = 1'b0;
    check("idle cancel hi", hi, 32'h1234);
    check("idle cancel busy", 32'(busy), 32'h0);

    // MTLO offered while busy stalls, then lands right after FIX.
    @(negedge clk); op = MULTU; a = 32'd3; b = 32'd5;
    @(negedge clk); op = MTLO; a = 32'hABCD; #1;
    check("busy mtlo stall", 32'(stall), 32'h1);
    check("busy mtlo lo held", lo, 32'h5678);
    n = 0;
    while (stall && n < 100) begin n++; @(negedge clk); #1; end
    check("busy mtlo stall cycles", 32'(n), 32'(LAT));
    check("product hi", hi, 32'h0);
    check("product lo", lo, 32'hF);
    @(negedge clk); op = NOP;
    check("late mtlo lo", lo, 32'hABCD);
    check("late mtlo hi", hi, 32'h0);

    // Asynchronous reset in the middle of RUN.
    run_op("pre rst mthi", MTHI, 32'h77, 32'h0, 32'h77, 32'hABCD, 0);
    @(negedge clk); op = MULT; a = 32'd2; b = 32'd3;
    @(negedge clk); op = NOP;
    repeat (5) @(negedge clk);
    rst = 1'b1; #1;
    check("midrun rst hi", hi, 32'h0);
    check("midrun rst lo", lo, 32'h0);
    check("midrun rst busy", 32'(busy), 32'h0);
    @(negedge clk); rst = 1'b0;

    // Randomized ops against the integer model.
    mhi = 32'h0; mlo = 32'h0;
    for (int k = 0; k < 40; k++) begin
      ro = 3'($urandom_range(1, 6));
      rx = pick();
      ry = pick();
      model(ro, rx, ry, c);
      run_op($sformatf("rand%0d op%0d", k, ro), ro, rx, ry, mhi, mlo, c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
